str_rca_16adder: RTL and testbench
==================================

Name: str_rca_16adder

Overview:
16-bit two's-complement/unsigned adder built structurally as a ripple-carry chain of full adders, with ALU-style status flags (sign, zero, carry, parity, overflow). Operands are sampled on the clock; sum and flags are registered. It serves as the structural-RCA reference adder in the 16-bit adder family, alongside other adder architectures with the same interface.

Parameters:
None. Width is fixed at 16 bits.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset; synchronous, active-high
a  input  16  operand A
b  input  16  operand B
c  output  16  registered sum, a+b mod 2^16
sign  output  1  registered sign flag, c[15]
zero  output  1  registered zero flag, 1 when c==16'h0000
carry  output  1  registered carry-out of bit 15
parity  output  1  registered even-parity flag, 1 when c has an even number of 1 bits (XNOR-reduce of c)
overflow  output  1  registered signed-overflow flag

Behaviour:
- One clock, one reset; all state updates on the rising edge of clk.
- Reset: rst=1 at a rising edge forces c=16'h0000 and sign=zero=carry=parity=overflow=0 on that edge. rst has priority over new operands. The first valid result appears one edge after rst deasserts.
- Datapath: purely combinational ripple chain of 16 full adders, organised as four 4-bit RCA slices (bits 3:0, 7:4, 11:8, 15:12). Each full adder computes sum=x^y^cin and cout=(x&y)|(cin&(x^y)). Carry-in to bit 0 is constant 0. No carry-lookahead.
- Flags are computed combinationally from the unregistered sum and the carries, then registered together with c:
  - sign = s[15]
  - zero = ~|s
  - carry = cout of bit 15
  - parity = ~^s
  - overflow = (a[15]==b[15]) && (s[15]!=a[15]), which is equivalent to cout15^cout14.
- Latency: operands present before rising edge N produce c and all flags valid after edge N (1-cycle latency). Throughput is one addition per cycle. The block has no handshake; a new result is produced every cycle.
- Outputs hold their values between edges. Changing a or b between edges does not affect the outputs until the next edge.
- Wrap-around: the sum is modulo 2^16. The carry bit is the 17th bit and is never folded back into c.
- Overflow and carry are independent. Both may be set in the same cycle, e.g. neg+neg giving a positive result.
- X-free: a design under test with all-known inputs must never produce X/Z on any output after reset.
- Timing budget: the critical path is the 16-stage ripple. No pipelining inside the adder.

Test Plan:
- Reset: rst=1 for 2 cycles with a=16'hffff, b=16'h0001 -> c=0000 and all five flags 0. After rst=0, the next edge gives c=0000, zero=1, carry=1, parity=1, sign=0, overflow=0.
- a=16'h8fff, b=16'h8000 -> c=16'h0fff, sign=0, zero=0, carry=1, parity=1, overflow=1.
- a=16'h6ffe, b=16'h0002 -> c=16'h7000, sign=0, zero=0, carry=0, parity=0, overflow=0.
- a=16'haaaa, b=16'h5555 -> c=16'hffff, sign=1, zero=0, carry=0, parity=1, overflow=0.
- a=16'h0000, b=16'h0000 -> c=16'h0000, sign=0, zero=1, carry=0, parity=1, overflow=0. Also a=16'h7fff, b=16'h0001 -> c=16'h8000, sign=1, overflow=1, carry=0, parity=0.
- Latency and back-to-back operation: apply a new operand pair every cycle. Each result must appear exactly one edge after its operands. Assert rst mid-stream -> outputs clear on that edge and the in-flight operands are discarded. Finish with a randomized comparison of {carry,c} against a+b over 17 bits, plus all flags.

Source files
------------

// File: rtl/str_rca_16adder.sv
// str_rca_16adder: 16-bit structural ripple-carry adder with registered sum and ALU flags
module str_rca_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module str_rca_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic [3:0] co
);
  logic [4:0] cy;
  assign cy[0] = ci;
  assign co = cy[4:1];
  for (genvar i = 0; i < 4; i++) begin : g_fa
    str_rca_fa u_fa (.x(x[i]), .y(y[i]), .ci(cy[i]), .s(s[i]), .co(cy[i+1]));
  end
endmodule

module str_rca_16adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        sign,
  output logic        zero,
  output logic        carry,
  output logic        parity,
  output logic        overflow
);
  logic [15:0] s;
  logic [16:0] cy;
  assign cy[0] = 1'b0;
  // cy[k] is the carry into bit k; cy[16] is the carry-out of bit 15
  for (genvar g = 0; g < 4; g++) begin : g_slice
    str_rca_4 u_rca (
      .x (a[4*g+3:4*g]),
      .y (b[4*g+3:4*g]),
      .ci(cy[4*g]),
      .s (s[4*g+3:4*g]),
      .co(cy[4*g+4:4*g+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      c        <= s;
      sign     <= s[15];
      zero     <= ~|s;
      carry    <= cy[16];
      parity   <= ~^s;
      overflow <= cy[16] ^ cy[15];
    end
  end
endmodule

// File: tb/tb_str_rca_16adder.sv
// tb_str_rca_16adder: scoreboard bench for str_rca_16adder with directed and random operands
module tb_str_rca_16adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a = '0, b = '0, c;
  logic sign, zero, carry, parity, overflow;
  typedef logic [20:0] exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  str_rca_16adder dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .sign(sign), .zero(zero), .carry(carry), .parity(parity), .overflow(overflow)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] t;
    int sx;
    t  = {1'b0, x} + {1'b0, y};
    sx = int'($signed(x)) + int'($signed(y));
    return {t[15:0], t[15], (t[15:0] == 16'h0), t[16],
            ($countones(t[15:0]) % 2 == 0), (sx > 32767 || sx < -32768)};
  endfunction

  task automatic step(input logic r, input logic [15:0] x, input logic [15:0] y, input exp_t ex);
    @(negedge clk);
    rst = r;
    a = x;
    b = y;
    q.push_back(r ? exp_t'(0) : ex);
  endtask

  task automatic rnd(input logic r, input logic [15:0] x, input logic [15:0] y);
    step(r, x, y, model(x, y));
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({c, sign, zero, carry, parity, overflow} !== e) begin
        bad++;
        $display("FAIL result: got c=%h s=%b z=%b cy=%b p=%b o=%b exp c=%h s=%b z=%b cy=%b p=%b o=%b",
                 c, sign, zero, carry, parity, overflow, e[20:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    step(1, 16'hffff, 16'h0001, '0);
    step(1, 16'hffff, 16'h0001, '0);
    step(0, 16'hffff, 16'h0001, {16'h0000, 5'b01110});
    step(0, 16'h8fff, 16'h8000, {16'h0fff, 5'b00111});
    step(0, 16'h6ffe, 16'h0002, {16'h7000, 5'b00000});
    step(0, 16'haaaa, 16'h5555, {16'hffff, 5'b10010});
    step(0, 16'h0000, 16'h0000, {16'h0000, 5'b01010});
    step(0, 16'h7fff, 16'h0001, {16'h8000, 5'b10001});
    step(0, 16'h8000, 16'h8000, {16'h0000, 5'b01111});
    step(0, 16'hffff, 16'hffff, {16'hfffe, 5'b10100});
    rnd(0, 16'h1234, 16'h4321);
    rnd(1, 16'hffff, 16'hffff);
    rnd(0, 16'h0001, 16'h0002);
    for (int i = 0; i < 400; i++)
      rnd(($urandom_range(39) == 0), 16'($urandom), 16'($urandom));
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
